decoder_share_arbiter: RTL and testbench

- Round-robin scheduler that time-shares a single 3-to-8 enable decoder (en, in[2:0] -> d[7:0]) between NUM_REQ requesters.
- Each requester asks for one decoder output line by index. The block grants one requester at a time and drives the decoder enable and select for a fixed hold window.
- It then releases the decoder and signals completion.
- Sits directly in front of the decoder instance; the decoder's en/in ports connect to dec_en/dec_in.

---
 rtl/decoder_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_decoder_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_share_arbiter.sv
// Round-robin arbiter time-sharing one 3-to-8 enable decoder between NUM_REQ requesters.
// Optional grant counter output is enabled with DEC_SHARE_ARB_GNT_CNT_EN.
module decoder_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int IDW         = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*IDW-1:0] req_idx,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   dec_en,
    output logic [IDW-1:0]         dec_in,
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
    output logic [7:0]             gnt_count,
`endif
    output logic                   busy
);

    localparam int                 PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_CYCLES);
    localparam logic [PW-1:0]      PTR_INIT  = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_r, state_n;
    logic [7:0]         cnt_r, cnt_n;
    logic [PW-1:0]      ptr_r, ptr_n;
    logic [PW-1:0]      owner_r, owner_n;
    logic [NUM_REQ-1:0] grant_r, grant_n;
    logic [NUM_REQ-1:0] done_r, done_n;
    logic               dec_en_r, dec_en_n;
    logic [IDW-1:0]     dec_in_r, dec_in_n;
    logic               busy_r, busy_n;
    logic               win_found_s;
    logic [PW-1:0]      win_idx_s;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
    logic [7:0]         gcnt_r, gcnt_n;
`endif

    // Round-robin winner search: first requester after ptr, wrapping.
    always_comb begin
        int cand;
        win_found_s = 1'b0;
        win_idx_s   = {PW{1'b0}};
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr_r) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!win_found_s && req[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = PW'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE -> HOLD -> RELEASE sequence.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        ptr_n    = ptr_r;
        owner_n  = owner_r;
        grant_n  = grant_r;
        done_n   = {NUM_REQ{1'b0}};
        dec_en_n = dec_en_r;
        dec_in_n = dec_in_r;
        busy_n   = busy_r;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
        gcnt_n   = gcnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    // req_idx is captured only here; the window ignores later changes.
                    owner_n  = win_idx_s;
                    grant_n  = ONE_HOT0 << win_idx_s;
                    dec_in_n = req_idx[int'(win_idx_s)*IDW +: IDW];
                    dec_en_n = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = 8'd1;
                    state_n  = ST_HOLD;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    dec_en_n = 1'b0;
                    dec_in_n = {IDW{1'b0}};
                    grant_n  = {NUM_REQ{1'b0}};
                    done_n   = ONE_HOT0 << owner_r;
                    ptr_n    = owner_r;
                    state_n  = ST_RELEASE;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
                    gcnt_n   = gcnt_r + 8'd1;
`endif
                end else begin
                    cnt_n    = cnt_r + 8'd1;
                end
            end
            ST_RELEASE: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n  = ST_IDLE;
                cnt_n    = 8'd0;
                grant_n  = {NUM_REQ{1'b0}};
                dec_en_n = 1'b0;
                dec_in_n = {IDW{1'b0}};
                busy_n   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            ptr_r    <= PTR_INIT;
            owner_r  <= {PW{1'b0}};
            grant_r  <= {NUM_REQ{1'b0}};
            done_r   <= {NUM_REQ{1'b0}};
            dec_en_r <= 1'b0;
            dec_in_r <= {IDW{1'b0}};
            busy_r   <= 1'b0;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
            gcnt_r   <= 8'd0;
`endif
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            ptr_r    <= ptr_n;
            owner_r  <= owner_n;
            grant_r  <= grant_n;
            done_r   <= done_n;
            dec_en_r <= dec_en_n;
            dec_in_r <= dec_in_n;
            busy_r   <= busy_n;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
            gcnt_r   <= gcnt_n;
`endif
        end
    end

    assign grant  = grant_r;
    assign done   = done_r;
    assign dec_en = dec_en_r;
    assign dec_in = dec_in_r;
    assign busy   = busy_r;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
    assign gnt_count = gcnt_r;
`endif

endmodule

// File: tb/tb_decoder_share_arbiter.sv
// Self-checking bench for decoder_share_arbiter: vector table, directed corner sequences,
// and randomized traffic against a window-phase reference model.
module tb_decoder_share_arbiter;

    localparam int N = 4;
    localparam int H = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*3-1:0]  req_idx;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            dec_en;
    logic [2:0]      dec_in;
    logic            busy;
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
    logic [7:0]      gnt_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: phase 0 = free, 1..H = decoder held, H+1 = release cycle.
    int          m_phase;
    int          m_owner;
    int          m_ptr;
    logic [2:0]  m_idx;
    int          m_cnt;

    always #5 clk = ~clk;

    decoder_share_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H), .IDW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_idx   (req_idx),
        .grant     (grant),
        .done      (done),
        .dec_en    (dec_en),
        .dec_in    (dec_in),
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
        .gnt_count (gnt_count),
`endif
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_phase = 0;
            m_ptr   = N - 1;
            m_owner = 0;
            m_idx   = 3'd0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_idx   = req_idx[3*c +: 3];
                    m_phase = 1;
                    break;
                end
            end
        end else if (m_phase < H) begin
            m_phase++;
        end else if (m_phase == H) begin
            m_phase = H + 1;
            m_ptr   = m_owner;
            m_cnt   = (m_cnt + 1) % 256;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_model();
        logic holding;
        holding = (m_phase >= 1) && (m_phase <= H);
        check("m_grant",  grant,  holding ? (32'd1 << m_owner) : 32'd0);
        check("m_done",   done,   (m_phase == H + 1) ? (32'd1 << m_owner) : 32'd0);
        check("m_dec_en", dec_en, {31'd0, holding});
        check("m_dec_in", dec_in, holding ? {29'd0, m_idx} : 32'd0);
        check("m_busy",   busy,   {31'd0, (m_phase != 0)});
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
        check("m_gnt_count", gnt_count, m_cnt);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_model();
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        logic [N-1:0] gnt;
        logic [N-1:0] dn;
        logic         en;
        logic [2:0]   din;
        logic         bsy;
    } vec_t;

    vec_t tbl[12];
    localparam logic [N*3-1:0] IDX_BASE = {3'd3, 3'd5, 3'd1, 3'd6};

    initial begin
        bit ok;
        int last_cyc;
        int en_cnt;
        int dn_cnt;
        logic [2:0] din0;
        logic [N*3-1:0] idx_v;
        logic [N-1:0] seen_done;

        reset   = 1'b0;
        req     = '0;
        req_idx = IDX_BASE;

        //            rst   req      grant    done     en    din   busy
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, 3'd6, 1'b1};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, 3'd6, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b1};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 3'd5, 1'b1};
        tbl[9]  = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 3'd5, 1'b1};
        tbl[10] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 3'd0, 1'b1};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};

        // Reset, first grant, single request window.
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].rq;
            tick();
            check("tbl_grant",  grant,  tbl[i].gnt);
            check("tbl_done",   done,   tbl[i].dn);
            check("tbl_dec_en", dec_en, tbl[i].en);
            check("tbl_dec_in", dec_in, tbl[i].din);
            check("tbl_busy",   busy,   tbl[i].bsy);
        end

        // Fairness under continuous requests: 0,1,2,3,0 spaced H+2 apart.
        do_reset();
        req = 4'b1111;
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(ok);
            check("fair_grant_seen", ok, 1);
            check("fair_owner", grant, 32'd1 << (g % N));
            idx_v = IDX_BASE;
            check("fair_dec_in", dec_in, idx_v[3*(g%N) +: 3]);
            if (g > 0) begin
                check("fair_spacing", cyc - last_cyc, H + 2);
            end else begin
                last_cyc = cyc;
            end
            last_cyc = cyc;
            wait_done(ok);
            check("fair_done_seen", ok, 1);
        end

        // Pointer wrap: after requester 3 completes, 0 wins before 3.
        req = 4'b0000;
        do_reset();
        req = 4'b1000;
        wait_grant(ok);
        check("wrap_first", grant, 4'b1000);
        wait_done(ok);
        check("wrap_done3", ok, 1);
        req = 4'b1001;
        wait_grant(ok);
        check("wrap_to0", grant, 4'b0001);
        wait_done(ok);
        wait_grant(ok);
        check("wrap_then3", grant, 4'b1000);
        wait_done(ok);
        req = 4'b0000;

        // Mid-window disturbance: owner changes req_idx and drops req.
        req = 4'b0010;
        wait_grant(ok);
        check("dist_grant", grant, 4'b0010);
        din0 = dec_in;
        check("dist_din", din0, 3'd1);
        req_idx[5:3] = 3'd7;
        req = 4'b0000;
        en_cnt = 1;
        seen_done = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dec_en) begin
                en_cnt++;
                check("dist_din_frozen", dec_in, din0);
            end else begin
                en_cnt = en_cnt;
            end
            if (done != 0) begin
                seen_done = done;
                break;
            end
        end
        check("dist_en_cycles", en_cnt, H);
        check("dist_done", seen_done, 4'b0010);
        req_idx = IDX_BASE;

        // Reset in the 2nd HOLD cycle abandons the window.
        req = 4'b0100;
        wait_grant(ok);
        check("rst_grant", grant, 4'b0100);
        tick();
        check("rst_hold2_en", dec_en, 1);
        reset = 1'b0;
        req = 4'b0000;
        tick();
        check("rst_all_zero", {grant, done, dec_en, dec_in, busy}, 0);
        reset = 1'b1;
        dn_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done != 0) dn_cnt++;
        end
        check("rst_no_done", dn_cnt, 0);
`ifdef DEC_SHARE_ARB_GNT_CNT_EN
        check("rst_gnt_count", gnt_count, 0);
`endif
        req = 4'b1111;
        wait_grant(ok);
        check("rst_then0", grant, 4'b0001);
        wait_done(ok);

`ifdef DEC_SHARE_ARB_GNT_CNT_EN
        // 300 completed windows wrap the 8-bit counter to 44.
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        dn_cnt = 0;
        for (int i = 0; i < 300 * (H + 2) + 20 && dn_cnt < 300; i++) begin
            tick();
            if (done != 0) dn_cnt++;
        end
        check("cnt_windows", dn_cnt, 300);
        check("cnt_value", gnt_count, 8'd44);
`endif

        // Randomized traffic with occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            req_idx = (N*3)'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
